hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised successor to the 2-bit-select dependency check / stall control pair in the 8-bit pipeline.
- Tracks destination registers of up to FWD_DEPTH in-flight instructions in a registered scoreboard.
- Drives per-operand forwarding selects with youngest-match priority, and inserts load-use stalls and bubbles.
- Sits between decode and the register bank operand muxes; its stall output gates the PC and IF/ID registers.

Parameters:
- REG_ADDR_W, 5, register address width (rs_a, rs_b, rd).
- FWD_DEPTH, 3, scoreboard entries = forwardable stages past decode (1=EX, 2=DM, 3=WB).
- LOAD_LAT, 1, load-use distance; a load in entry k with k <= LOAD_LAT cannot forward yet. Legal range 1..FWD_DEPTH-1.
- SEL_W, $clog2(FWD_DEPTH+1), forwarding select width (2 at defaults).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs_a  in  REG_ADDR_W  source A register
- id_rs_b  in  REG_ADDR_W  source B register
- id_use_a  in  1  instruction reads rs_a
- id_use_b  in  1  instruction reads rs_b (0 when immediate selected)
- id_rd  in  REG_ADDR_W  destination register
- id_wr_en  in  1  instruction writes rd
- id_is_load  in  1  result comes from data memory
- flush  in  1  jump/interrupt taken; kill all tracked instructions
- fwd_sel_a  out  SEL_W  0=register file, k=result of entry k
- fwd_sel_b  out  SEL_W  same for operand B
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  registered; the stage after decode holds a NOP this cycle
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- Scoreboard:
  - Entry e[k], k=1..FWD_DEPTH, holds {v, wr, rd, ld}. All fields are registers.
  - Reset (async) clears every v, bubble and stall_count.
- Match rule: e[k] matches operand X when all of these hold: e[k].v, e[k].wr, e[k].rd==id_rs_X, id_use_X and id_valid.
- fwd_sel_X (combinational, same cycle):
  - Equals the smallest matching k (youngest wins).
  - Equals 0 if there is no match.
  - Equals 0 while stall=1.
- stall (combinational):
  - Asserts when either operand's youngest match has e[k].ld=1 and k <= LOAD_LAT.
  - Forced 0 when flush=1 or id_valid=0.
- Shift at each clk edge, unless reset:
  - e[k+1] <= e[k] for k=1..FWD_DEPTH-1; e[FWD_DEPTH] retires.
  - e[1] <= {id_valid, id_wr_en, id_rd, id_is_load} when stall=0 and flush=0.
  - e[1].v <= 0 (bubble) when stall=1.
- flush=1:
  - Next edge clears v of all entries (including e[1]).
  - Flush beats stall on the same cycle.
- bubble <= stall | flush, registered, 1-cycle latency.
- stall_count increments on each edge where stall=1 and saturates at 16'hFFFF.
- Stall duration:
  - A dependent instruction stalls (LOAD_LAT - k + 1) cycles, where k is the load's entry index when the dependence is first seen.
  - At defaults, a load immediately followed by a user stalls exactly 1 cycle, then forwards from entry 2 (DM).
- Same register matched in several entries: youngest wins, including a non-load in e[1] shadowing an older load.
- Both operands stall independently; stall is their OR; both selects are computed in the same cycle.
- id_rd equal to id_rs of the same instruction: no self-match (the entry is not yet written).
- Reset mid-stall: stall drops immediately (entries invalid); no partial shift.

Optional Feature:
- Macro: HAZARD_ZERO_REG_EN.
- When defined:
  - Register address 0 is hardwired zero.
  - An entry with rd==0 never matches; fwd_sel=0 and no stall for rs==0.
  - e[1].wr is forced 0 when id_rd==0.
- When undefined: register 0 is treated like any other register.

Test Plan:
1. ADD r3 writes; next cycle a user reads rs_a=3 → fwd_sel_a=1, stall=0. One cycle later a second user reads rs_a=3 → fwd_sel_a=2.
2. LOAD r5, then an immediate user with rs_b=5, use_b=1 → stall=1 for 1 cycle, bubble=1 the next cycle, then fwd_sel_b=2, stall_count=1.
3. ADD r4 at t, ADD r4 at t+1, user rs_a=4 at t+2 → fwd_sel_a=1 (youngest), never 2.
4. LOAD r6 then user rs_a=6 with flush=1 in the same cycle → stall=0, bubble=1 next cycle, all entries invalid; a following user of r6 gets fwd_sel_a=0.
5. Assert reset during a load-use stall → stall, bubble, fwd_sel_a/b and stall_count all 0 immediately, without a clock edge.
6. With HAZARD_ZERO_REG_EN: LOAD r0 then user rs_a=0 → stall=0, fwd_sel_a=0. Without the macro, the same stimulus gives stall=1.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//
// Purpose:
//   Data-hazard unit that sits between decode and the operand muxes.
//   - Keeps a registered scoreboard of the destination registers of the
//     instructions in flight past decode (entry 1 = EX, 2 = DM, 3 = WB at
//     the default depth).
//   - Selects per-operand forwarding sources; the youngest match wins.
//   - Stalls the front end on load-use hazards and injects a bubble.
//
// Parameters:
//   REG_ADDR_W - register address width
//   FWD_DEPTH  - number of scoreboard entries (forwardable stages)
//   LOAD_LAT   - a load in entry k <= LOAD_LAT cannot forward yet
//                (legal range 1..FWD_DEPTH-1)
//   SEL_W      - forwarding select width
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   id_valid                 decode holds a real instruction
//   id_rs_a/id_rs_b          source registers
//   id_use_a/id_use_b        operand actually reads its source register
//   id_rd/id_wr_en           destination register and its write enable
//   id_is_load               result comes from data memory
//   flush                    kill all tracked instructions
//   fwd_sel_a/fwd_sel_b      0 = register file, k = result of entry k
//   stall                    hold PC and IF/ID this cycle
//   bubble                   registered; stage after decode holds a NOP
//   stall_count              saturating count of stall cycles
//
// Optional feature:
//   HAZARD_ZERO_REG_EN - when defined, register 0 is hardwired zero.
//   It never matches and is never recorded as written.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the
// decode fields for one cycle; stall tells the front end to present the
// same instruction again on the next cycle.

module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic                  stall,
    output logic                  bubble,
    output logic [15:0]           stall_count
);

    // Scoreboard: entry k holds {v, wr, rd, ld}.
    logic [FWD_DEPTH:1]    e_v;
    logic [FWD_DEPTH:1]    e_wr;
    logic [FWD_DEPTH:1]    e_ld;
    logic [REG_ADDR_W-1:0] e_rd [1:FWD_DEPTH];

    logic [FWD_DEPTH:1] match_a;
    logic [FWD_DEPTH:1] match_b;
    logic [SEL_W-1:0]   sel_a_raw;
    logic [SEL_W-1:0]   sel_b_raw;
    logic               load_hit_a;
    logic               load_hit_b;
    logic               wr_in;

`ifdef HAZARD_ZERO_REG_EN
    // Writes to r0 are discarded, so they are never recorded as producers.
    assign wr_in = id_wr_en && (id_rd != '0);
`else
    assign wr_in = id_wr_en;
`endif

    // Per-entry match. The decoding instruction is not in the scoreboard
    // yet, so rd == rs of the same instruction cannot self-match.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            match_a[k] = e_v[k] && e_wr[k] && (e_rd[k] == id_rs_a) && id_use_a && id_valid;
            match_b[k] = e_v[k] && e_wr[k] && (e_rd[k] == id_rs_b) && id_use_b && id_valid;
`ifdef HAZARD_ZERO_REG_EN
            if (e_rd[k] == '0) begin
                match_a[k] = 1'b0;
                match_b[k] = 1'b0;
            end
`endif
        end
    end

    // Youngest match wins: scan oldest to youngest so the smallest k is the
    // last one written. The load-use test applies only to that youngest
    // match, which lets a younger ALU result shadow an older load.
    always_comb begin
        sel_a_raw  = '0;
        sel_b_raw  = '0;
        load_hit_a = 1'b0;
        load_hit_b = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (match_a[k]) begin
                sel_a_raw  = SEL_W'(k);
                load_hit_a = e_ld[k] && (k <= LOAD_LAT);
            end
            if (match_b[k]) begin
                sel_b_raw  = SEL_W'(k);
                load_hit_b = e_ld[k] && (k <= LOAD_LAT);
            end
        end
    end

    // Flush beats stall: the stalled instruction is being killed anyway.
    assign stall     = (load_hit_a || load_hit_b) && id_valid && !flush;
    assign fwd_sel_a = stall ? '0 : sel_a_raw;
    assign fwd_sel_b = stall ? '0 : sel_b_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_v         <= '0;
            e_wr        <= '0;
            e_ld        <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                e_rd[k] <= '0;
            end
            bubble      <= 1'b0;
            stall_count <= '0;
        end else begin
            // Older entries advance every cycle; the oldest simply retires.
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                e_v[k]  <= e_v[k-1] && !flush;
                e_wr[k] <= e_wr[k-1];
                e_ld[k] <= e_ld[k-1];
                e_rd[k] <= e_rd[k-1];
            end
            // A stalled or flushed decode slot enters as an invalid bubble.
            e_v[1]  <= id_valid && !stall && !flush;
            e_wr[1] <= wr_in;
            e_ld[1] <= id_is_load;
            e_rd[1] <= id_rd;

            bubble <= stall || flush;
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs_a;
    logic [4:0] id_rs_b;
    logic       id_use_a;
    logic       id_use_b;
    logic [4:0] id_rd;
    logic       id_wr_en;
    logic       id_is_load;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;
    logic       bubble;
    logic [15:0] stall_count;

    int checks;
    int errors;

    hazard_fwd_unit dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs_a    (id_rs_a),
        .id_rs_b    (id_rs_b),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_rd      (id_rd),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .flush      (flush),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall      (stall),
        .bubble     (bubble),
        .stall_count(stall_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks. Inputs change 1 ns after a rising edge; outputs are
    // sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ra, input logic ua,
                         input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic fl);
        id_valid   = v;
        id_rs_a    = ra;
        id_use_a   = ua;
        id_rs_b    = rb;
        id_use_b   = ub;
        id_rd      = rd;
        id_wr_en   = wr;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b bubble=%b sel_a=%0d sel_b=%0d want 0 0 0 0",
                     stall, bubble, fwd_sel_a, fwd_sel_b);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", stall_count);
        end
        step();
    endtask

    // ADD r3, then two users of r3 on consecutive cycles.
    task automatic test_alu_forward();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (fwd_sel_a !== 2'd1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd_ex got sel_a=%0d stall=%b want 1 0", fwd_sel_a, stall);
        end
        checks++;
        if (fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL alu_nomatch_b got %0d want 0", fwd_sel_b);
        end
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (fwd_sel_a !== 2'd2 || stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd_dm got sel_a=%0d stall=%b want 2 0", fwd_sel_a, stall);
        end
        step();
        idle(4);
    endtask

    // LOAD r5 then an immediate user on operand B.
    task automatic test_load_use();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL load_use_stall got stall=%b sel_b=%0d want 1 0", stall, fwd_sel_b);
        end
        step();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b1 || fwd_sel_b !== 2'd2) begin
            errors++;
            $display("FAIL load_use_resolve got stall=%b bubble=%b sel_b=%0d want 0 1 2",
                     stall, bubble, fwd_sel_b);
        end
        checks++;
        if (stall_count !== 16'd1) begin
            errors++;
            $display("FAIL load_use_count got %0d want 1", stall_count);
        end
        step();
        idle(1);
        @(negedge clk);
        checks++;
        if (bubble !== 1'b0) begin
            errors++;
            $display("FAIL bubble_one_cycle got %b want 0", bubble);
        end
        idle(3);
    endtask

    // Two writers of r4 back to back; then a younger ALU op shadowing a load.
    task automatic test_youngest();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1) begin
            errors++;
            $display("FAIL youngest_wins got sel_a=%0d sel_b=%0d want 1 1", fwd_sel_a, fwd_sel_b);
        end
        step();
        idle(4);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd14, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (fwd_sel_a !== 2'd1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_shadows_load got sel_a=%0d stall=%b want 1 0", fwd_sel_a, stall);
        end
        step();
        idle(4);
    endtask

    // Both operands depend on the same load; self-reference does not match.
    task automatic test_both_operands();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL both_stall got stall=%b sel_a=%0d sel_b=%0d want 1 0 0",
                     stall, fwd_sel_a, fwd_sel_b);
        end
        step();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd2 || stall_count !== 16'd2) begin
            errors++;
            $display("FAIL both_resolve got stall=%b sel_a=%0d sel_b=%0d cnt=%0d want 0 2 2 2",
                     stall, fwd_sel_a, fwd_sel_b, stall_count);
        end
        step();
        idle(4);
        drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (fwd_sel_a !== 2'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL no_self_match got sel_a=%0d stall=%b want 0 0", fwd_sel_a, stall);
        end
        step();
        idle(4);
    endtask

    // LOAD r6, then a user in the same cycle as a flush.
    task automatic test_flush();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_stall got stall=%b want 0", stall);
        end
        step();
        drive(1'b1, 5'd6, 1'b1, 5'd16, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bubble !== 1'b1 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears got bubble=%b sel_a=%0d sel_b=%0d stall=%b want 1 0 0 0",
                     bubble, fwd_sel_a, fwd_sel_b, stall);
        end
        checks++;
        if (stall_count !== 16'd2) begin
            errors++;
            $display("FAIL flush_count got %0d want 2", stall_count);
        end
        step();
        idle(4);
    endtask

    // Reset asserted mid-stall, then again while bubble is high.
    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd18, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall got %b want 1", stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 ||
            stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_stall got stall=%b bubble=%b sel_a=%0d sel_b=%0d cnt=%0d want all 0",
                     stall, bubble, fwd_sel_a, fwd_sel_b, stall_count);
        end
        idle(2);
        reset = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0);
        step();
        #1;
        checks++;
        if (bubble !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bubble got %b want 1", bubble);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bubble !== 1'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_bubble got bubble=%b cnt=%0d want 0 0", bubble, stall_count);
        end
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    // LOAD r0 followed by a user of r0.
    task automatic test_zero_reg();
        logic exp_stall;
`ifdef HAZARD_ZERO_REG_EN
        exp_stall = 1'b0;
`else
        exp_stall = 1'b1;
`endif
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd19, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (stall !== exp_stall || fwd_sel_a !== 2'd0) begin
            errors++;
            $display("FAIL zero_reg got stall=%b sel_a=%0d want %b 0", stall, fwd_sel_a, exp_stall);
        end
        step();
        idle(4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        do_reset();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_both_operands();
        test_flush();
        test_reset_mid_stall();
        test_zero_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
